// File: rtl/suma_sat_pipe.sv
// suma_sat_pipe: two-stage pipelined signed saturating add/sub/accumulate unit.
// Stage 1 forms the exact Width+1 bit sum; stage 2 clamps it to the signed
// Width-bit range and raises ovf/unf.
// Valid/ready handshake on both sides, with full throughput and backpressure.
// Optional build macro SUMA_SAT_CNT_EN adds a 16-bit sticky counter
// (sat_count) of saturated output transfers.
module suma_sat_pipe #(
  parameter int Width = 22
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] Y,
  output logic             ovf,
  output logic             unf
`ifdef SUMA_SAT_CNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  // Clamp limits at result width and at the extended sum width.
  localparam logic signed [Width-1:0] MAXV   = {1'b0, {(Width-1){1'b1}}};
  localparam logic signed [Width-1:0] MINV   = {1'b1, {(Width-1){1'b0}}};
  localparam logic signed [Width:0]   MAXV_X = {2'b00, {(Width-1){1'b1}}};
  localparam logic signed [Width:0]   MINV_X = {2'b11, {(Width-1){1'b0}}};

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;
  localparam logic [1:0] MODE_LD  = 2'b11;

  // Saturate an exact Width+1 bit sum into the Width-bit signed range.
  function automatic logic [Width-1:0] sat_val(input logic signed [Width:0] s);
    logic [Width-1:0] r;
    if (s > MAXV_X) begin
      r = MAXV;
    end else if (s < MINV_X) begin
      r = MINV;
    end else begin
      r = s[Width-1:0];
    end
    return r;
  endfunction

  function automatic logic is_ovf(input logic signed [Width:0] s);
    return (s > MAXV_X);
  endfunction

  function automatic logic is_unf(input logic signed [Width:0] s);
    return (s < MINV_X);
  endfunction

  // State
  logic                    s1_valid_q, s1_valid_d;
  logic signed [Width:0]   s1_sum_q,   s1_sum_d;
  logic [Width-1:0]        acc_q,      acc_d;
  logic                    out_valid_q, out_valid_d;
  logic [Width-1:0]        y_q,        y_d;
  logic                    ovf_q,      ovf_d;
  logic                    unf_q,      unf_d;

  // Combinational helpers
  logic signed [Width:0]   a_x_s, b_x_s, acc_x_s, sum_s;
  logic                    s2_take_s;
  logic                    accept_s;

  // Stage 2 can take a new entry when empty or when its result leaves now.
  assign s2_take_s = ~out_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_take_s;
  assign accept_s  = in_valid & in_ready;

  // Exact sum at Width+1 bits; negating the extended B keeps B=MINV exact.
  always_comb begin
    a_x_s   = {A[Width-1], A};
    b_x_s   = {B[Width-1], B};
    acc_x_s = {acc_q[Width-1], acc_q};
    sum_s   = a_x_s;
    case (mode)
      MODE_ADD: sum_s = a_x_s + b_x_s;
      MODE_SUB: sum_s = a_x_s + (-b_x_s);
      MODE_ACC: sum_s = acc_x_s + a_x_s;
      MODE_LD:  sum_s = a_x_s;
      default:  sum_s = a_x_s;
    endcase
  end

  // Next-state for stage 1 and the accumulator.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    acc_d      = acc_q;
    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = sum_s;
      case (mode)
        MODE_ACC: acc_d = sat_val(sum_s);
        MODE_LD:  acc_d = A;
        default:  acc_d = acc_q;
      endcase
    end else if (s2_take_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Next-state for stage 2: saturate when stage 1 moves forward, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (s2_take_s) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        y_d   = sat_val(s1_sum_q);
        ovf_d = is_ovf(s1_sum_q);
        unf_d = is_unf(s1_sum_q);
      end else begin
        y_d   = y_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline and accumulator registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;

`ifdef SUMA_SAT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count saturated results as they leave; stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q & out_ready & (ovf_q | unf_q) & (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat_count = cnt_q;
`endif

endmodule

// File: tb/tb_suma_sat_pipe.sv
// Directed self-checking bench for suma_sat_pipe (Width=22).
module tb_suma_sat_pipe;

  localparam int W = 22;
  localparam logic signed [W-1:0] MAXV = 22'sd2097151;
  localparam logic signed [W-1:0] MINV = -22'sd2097151 - 22'sd1;

  logic clk;
  logic reset;
  logic in_valid;
  logic in_ready;
  logic [1:0] mode;
  logic signed [W-1:0] A;
  logic signed [W-1:0] B;
  logic out_valid;
  logic out_ready;
  logic signed [W-1:0] Y;
  logic ovf;
  logic unf;
`ifdef SUMA_SAT_CNT_EN
  logic [15:0] sat_count;
`endif

  int errors = 0;
  int checks = 0;

  // beat tables and captured outputs
  logic [1:0]          b_mode [0:15];
  logic signed [W-1:0] b_a    [0:15];
  logic signed [W-1:0] b_b    [0:15];
  int                  got_n;
  logic signed [W-1:0] got_y  [0:15];
  logic                got_ovf[0:15];
  logic                got_unf[0:15];
  logic                tr_ir  [0:63];
  logic                tr_ov  [0:63];
  logic signed [W-1:0] tr_y   [0:63];

  suma_sat_pipe #(.Width(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Y         (Y),
    .ovf       (ovf),
    .unf       (unf)
`ifdef SUMA_SAT_CNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive n beats from the tables, stall output during [stall_lo, stall_hi],
  // and collect every output transfer plus a per-cycle trace.
  task automatic run_beats(input int n, input int stall_lo, input int stall_hi, input int max_cyc);
    int sent;
    sent  = 0;
    got_n = 0;
    for (int c = 0; c < max_cyc && c < 64 && got_n < n; c++) begin
      out_ready = !(c >= stall_lo && c <= stall_hi);
      in_valid  = (sent < n);
      if (sent < n) begin
        mode = b_mode[sent];
        A    = b_a[sent];
        B    = b_b[sent];
      end
      #1;
      tr_ir[c] = in_ready;
      tr_ov[c] = out_valid;
      tr_y[c]  = Y;
      if (out_valid && out_ready && got_n < 16) begin
        got_y[got_n]   = Y;
        got_ovf[got_n] = ovf;
        got_unf[got_n] = unf;
        got_n++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; A = '0; B = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (Y !== 22'sd0) begin errors++; $display("FAIL reset_Y: got %0d want 0", Y); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL reset_flags: got ovf=%0b unf=%0b want 0 0", ovf, unf); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_add_latency;
    out_ready = 1'b1;
    in_valid = 1'b1; mode = 2'b00; A = 22'sd1000; B = -22'sd250;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_accept: got in_ready=%0b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_lat1: got out_valid=%0b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_lat2: got out_valid=%0b want 1", out_valid); end
    checks++; if (Y !== 22'sd750) begin errors++; $display("FAIL add_Y: got %0d want 750", Y); end
    checks++; if (ovf !== 1'b0 || unf !== 1'b0) begin errors++; $display("FAIL add_flags: got ovf=%0b unf=%0b want 0 0", ovf, unf); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain: got out_valid=%0b want 0", out_valid); end
  endtask

  task automatic test_saturation;
    logic signed [W-1:0] ey [0:2];
    logic eo [0:2];
    logic eu [0:2];
    b_mode[0] = 2'b00; b_a[0] = 22'sd2097000;  b_b[0] = 22'sd500;
    b_mode[1] = 2'b01; b_a[1] = -22'sd2097000; b_b[1] = 22'sd500;
    b_mode[2] = 2'b01; b_a[2] = 22'sd0;        b_b[2] = MINV;
    ey[0] = MAXV; eo[0] = 1'b1; eu[0] = 1'b0;
    ey[1] = MINV; eo[1] = 1'b0; eu[1] = 1'b1;
    ey[2] = MAXV; eo[2] = 1'b1; eu[2] = 1'b0;
    run_beats(3, -1, -1, 20);
    checks++; if (got_n != 3) begin errors++; $display("FAIL sat_count_out: got %0d results want 3", got_n); end
    for (int i = 0; i < 3 && i < got_n; i++) begin
      checks++;
      if (got_y[i] !== ey[i] || got_ovf[i] !== eo[i] || got_unf[i] !== eu[i]) begin
        errors++;
        $display("FAIL sat_beat%0d: got Y=%0d ovf=%0b unf=%0b want Y=%0d ovf=%0b unf=%0b",
                 i, got_y[i], got_ovf[i], got_unf[i], ey[i], eo[i], eu[i]);
      end
    end
  endtask

  task automatic test_accumulate;
    logic signed [W-1:0] ey [0:2];
    logic eo [0:2];
    b_mode[0] = 2'b11; b_a[0] = 22'sd2097100; b_b[0] = 22'sd7;
    b_mode[1] = 2'b10; b_a[1] = 22'sd100;     b_b[1] = 22'sd7;
    b_mode[2] = 2'b10; b_a[2] = -22'sd50;     b_b[2] = 22'sd7;
    ey[0] = 22'sd2097100; eo[0] = 1'b0;
    ey[1] = MAXV;         eo[1] = 1'b1;
    ey[2] = 22'sd2097101; eo[2] = 1'b0;
    run_beats(3, -1, -1, 20);
    checks++; if (got_n != 3) begin errors++; $display("FAIL acc_count_out: got %0d results want 3", got_n); end
    for (int i = 0; i < 3 && i < got_n; i++) begin
      checks++;
      if (got_y[i] !== ey[i] || got_ovf[i] !== eo[i] || got_unf[i] !== 1'b0) begin
        errors++;
        $display("FAIL acc_beat%0d: got Y=%0d ovf=%0b unf=%0b want Y=%0d ovf=%0b unf=0",
                 i, got_y[i], got_ovf[i], got_unf[i], ey[i], eo[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    logic signed [W-1:0] ev;
    for (int i = 0; i < 6; i++) begin
      b_mode[i] = 2'b00;
      b_a[i]    = W'(i + 1);
      b_b[i]    = 22'sd10;
    end
    run_beats(6, 3, 6, 40);
    checks++; if (got_n != 6) begin errors++; $display("FAIL bp_count_out: got %0d results want 6", got_n); end
    for (int i = 0; i < 6 && i < got_n; i++) begin
      ev = W'(i + 11);
      checks++;
      if (got_y[i] !== ev) begin errors++; $display("FAIL bp_order%0d: got Y=%0d want %0d", i, got_y[i], ev); end
    end
    checks++; if (tr_ir[2] !== 1'b1) begin errors++; $display("FAIL bp_ready_c2: got %0b want 1", tr_ir[2]); end
    checks++; if (tr_ir[3] !== 1'b0) begin errors++; $display("FAIL bp_ready_c3: got %0b want 0", tr_ir[3]); end
    for (int c = 3; c <= 6; c++) begin
      checks++;
      if (tr_ov[c] !== 1'b1 || tr_y[c] !== 22'sd12) begin
        errors++;
        $display("FAIL bp_hold_c%0d: got out_valid=%0b Y=%0d want 1 12", c, tr_ov[c], tr_y[c]);
      end
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    in_valid = 1'b1; mode = 2'b11; A = 22'sd777; B = 22'sd0;
    @(posedge clk); #1;
    mode = 2'b10; A = 22'sd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight: got out_valid=%0b want 1", out_valid); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || Y !== 22'sd0) begin errors++; $display("FAIL mid_flush: got out_valid=%0b Y=%0d want 0 0", out_valid, Y); end
    b_mode[0] = 2'b10; b_a[0] = 22'sd5; b_b[0] = 22'sd0;
    run_beats(1, -1, -1, 10);
    checks++; if (got_n != 1) begin errors++; $display("FAIL mid_count_out: got %0d results want 1", got_n); end
    checks++; if (got_y[0] !== 22'sd5 || got_ovf[0] !== 1'b0) begin errors++; $display("FAIL mid_acc_zero: got Y=%0d ovf=%0b want 5 0", got_y[0], got_ovf[0]); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_extra: got out_valid=%0b want 0", out_valid); end
  endtask

`ifdef SUMA_SAT_CNT_EN
  task automatic test_sat_counter;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (sat_count !== 16'd0) begin errors++; $display("FAIL cnt_reset: got %0d want 0", sat_count); end
    b_mode[0] = 2'b00; b_a[0] = MAXV;     b_b[0] = 22'sd1;
    b_mode[1] = 2'b00; b_a[1] = 22'sd0;   b_b[1] = 22'sd5;
    b_mode[2] = 2'b01; b_a[2] = MINV;     b_b[2] = 22'sd1;
    b_mode[3] = 2'b00; b_a[3] = 22'sd3;   b_b[3] = 22'sd4;
    b_mode[4] = 2'b01; b_a[4] = 22'sd0;   b_b[4] = MINV;
    run_beats(5, -1, -1, 20);
    checks++; if (sat_count !== 16'd3) begin errors++; $display("FAIL cnt_three: got %0d want 3", sat_count); end
    in_valid = 1'b1; out_ready = 1'b1; mode = 2'b00; A = MAXV; B = 22'sd1;
    repeat (65545) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sat_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_stick: got %0d want 65535", sat_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_latency();
    test_saturation();
    test_accumulate();
    test_backpressure();
    test_reset_mid();
`ifdef SUMA_SAT_CNT_EN
    test_sat_counter();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
